instruction_memory_server: RTL and testbench

INSTRUCTION_MEMORY_SERVER -- requirements
Module: instruction_memory_server

---
 rtl/instruction_memory_server.sv | 121 ++++++++++++
 tb/tb_instruction_memory_server.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_server.sv
// rtl/instruction_memory_server.sv - ternary instruction store: word-by-word loader plus 1-cycle fetch port
module instruction_memory_server #(
  parameter int WORD_SIZE  = 9,
  parameter int MEM_DEPTH  = 27,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic                    load_last,
  input  logic [2*WORD_SIZE-1:0]  load_data,
  input  logic                    fetch_enable,
  input  logic [ADDR_WIDTH-1:0]   ins_pointer,
  output logic [2*WORD_SIZE-1:0]  instruction,
  output logic                    instruction_valid,
  output logic                    fetch_error,
  output logic                    load_error,
  output logic                    loaded,
  output logic [ADDR_WIDTH:0]     load_count
);

  localparam int W = 2 * WORD_SIZE;
  localparam logic [ADDR_WIDTH:0] DEPTH     = MEM_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  load_error_next;
  logic                  mem_we;
  logic                  fetch_ok;
  logic                  ptr_in_range;
  logic [W-1:0]          mem [0:MEM_DEPTH-1];

  // 2'b11 is not a legal trit encoding anywhere in a word
  function automatic logic has_bad_trit(input logic [W-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (word[2*i +: 2] == 2'b11) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    state_next      = state;
    count_next      = load_count;
    load_error_next = load_error;
    mem_we          = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_next      = S_LOAD;
          count_next      = '0;
          load_error_next = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          count_next      = '0;
          load_error_next = 1'b0;
        end else if (load_valid) begin
          if (load_count >= DEPTH) begin
            state_next = S_READY;
          end else if (has_bad_trit(load_data)) begin
            load_error_next = 1'b1;
            if (load_last) state_next = S_READY;
          end else begin
            mem_we     = 1'b1;
            count_next = load_count + COUNT_ONE;
            if (load_last || (count_next == DEPTH)) state_next = S_READY;
          end
        end
      end
      S_READY: begin
        if (load_start) begin
          state_next      = S_LOAD;
          count_next      = '0;
          load_error_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A load_start in READY wins over a same-cycle fetch
  assign fetch_ok     = fetch_enable && (state == S_READY) && !load_start;
  assign ptr_in_range = ({1'b0, ins_pointer} < DEPTH);

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      load_count        <= '0;
      load_error        <= 1'b0;
      loaded            <= 1'b0;
      instruction       <= '0;
      instruction_valid <= 1'b0;
      fetch_error       <= 1'b0;
    end else begin
      state             <= state_next;
      load_count        <= count_next;
      load_error        <= load_error_next;
      loaded            <= (state_next == S_READY);
      instruction_valid <= fetch_ok;
      fetch_error       <= fetch_enable && !(fetch_ok && ptr_in_range);
      if (fetch_ok) instruction <= ptr_in_range ? mem[ins_pointer] : '0;
    end
  end

  // Storage is deliberately not reset; reset only blocks a same-cycle write
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[load_count[ADDR_WIDTH-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_instruction_memory_server.sv
// tb/tb_instruction_memory_server.sv - vector table, directed full-depth load, random run against a reference model
module tb_instruction_memory_server;

  localparam int DEPTH = 27;

  logic        clock = 1'b0;
  logic        reset, load_start, load_valid, load_last, fetch_enable;
  logic [17:0] load_data;
  logic [4:0]  ins_pointer;
  logic [17:0] instruction;
  logic        instruction_valid, fetch_error, load_error, loaded;
  logic [5:0]  load_count;

  int checks   = 0;
  int failures = 0;

  instruction_memory_server dut (
    .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_last(load_last), .load_data(load_data), .fetch_enable(fetch_enable),
    .ins_pointer(ins_pointer), .instruction(instruction),
    .instruction_valid(instruction_valid), .fetch_error(fetch_error),
    .load_error(load_error), .loaded(loaded), .load_count(load_count)
  );

  always #5 clock = ~clock;

  // Reference model: words stored so far, whether programming or serving, and expected outputs
  logic [17:0] m_mem [0:DEPTH-1];
  bit          m_loading, m_ready, m_lerr, m_ival, m_ferr;
  int          m_count;
  logic [17:0] m_instr;

  task automatic model_step();
    bit bad, take;
    if (reset) begin
      m_loading = 0; m_ready = 0; m_count = 0; m_lerr = 0;
      m_instr = '0; m_ival = 0; m_ferr = 0;
      return;
    end
    take   = fetch_enable && m_ready && !load_start;
    m_ival = take;
    m_ferr = fetch_enable && !(take && int'(ins_pointer) < DEPTH);
    if (take) m_instr = (int'(ins_pointer) < DEPTH) ? m_mem[ins_pointer] : '0;
    if (load_start) begin
      m_loading = 1; m_ready = 0; m_count = 0; m_lerr = 0;
    end else if (m_loading && load_valid) begin
      bad = 0;
      for (int i = 0; i < 9; i++) if (load_data[2*i +: 2] == 2'b11) bad = 1;
      if (m_count >= DEPTH) begin
        m_loading = 0; m_ready = 1;
      end else if (bad) begin
        m_lerr = 1;
        if (load_last) begin m_loading = 0; m_ready = 1; end
      end else begin
        m_mem[m_count] = load_data;
        m_count++;
        if (load_last || m_count == DEPTH) begin m_loading = 0; m_ready = 1; end
      end
    end
  endtask

  task automatic apply(input logic r, input logic ls, input logic lv, input logic ll,
                       input logic [17:0] d, input logic fe, input logic [4:0] p);
    reset = r; load_start = ls; load_valid = lv; load_last = ll;
    load_data = d; fetch_enable = fe; ins_pointer = p;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_outs(input string tag, input logic [17:0] ei, input logic eiv,
                            input logic efe, input logic ele, input logic eld,
                            input logic [5:0] ec);
    check({tag, "_instruction"}, 32'(instruction), 32'(ei));
    check({tag, "_instruction_valid"}, 32'(instruction_valid), 32'(eiv));
    check({tag, "_fetch_error"}, 32'(fetch_error), 32'(efe));
    check({tag, "_load_error"}, 32'(load_error), 32'(ele));
    check({tag, "_loaded"}, 32'(loaded), 32'(eld));
    check({tag, "_load_count"}, 32'(load_count), 32'(ec));
  endtask

  function automatic logic [17:0] trit_word(input int k);
    logic [17:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[2*i] = k[i];
    return w;
  endfunction

  typedef struct {
    logic        rst, ls, lv, ll;
    logic [17:0] d;
    logic        fe;
    logic [4:0]  p;
    logic [17:0] ei;
    logic        eiv, efe, ele, eld;
    logic [5:0]  ec;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [17:0] d;
    //                rst ls lv ll data      fe ptr | instr     iv fe le ld cnt
    vecs.push_back('{1, 0, 0, 0, 18'h00000, 0, 0,  18'h00000, 0, 0, 0, 0, 0}); // reset state
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 0,  18'h00000, 0, 1, 0, 0, 0}); // fetch unprogrammed
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 0, 0,  18'h00000, 0, 0, 0, 0, 0}); // error is a pulse
    vecs.push_back('{0, 1, 0, 0, 18'h00000, 0, 0,  18'h00000, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 18'h00001, 0, 0,  18'h00000, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 18'h00015, 0, 0,  18'h00000, 0, 0, 0, 0, 2});
    vecs.push_back('{0, 0, 1, 1, 18'h2AAAA, 0, 0,  18'h00000, 0, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 0,  18'h00001, 1, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 1,  18'h00015, 1, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 2,  18'h2AAAA, 1, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 27, 18'h00000, 1, 1, 0, 1, 3}); // first bad pointer
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 31, 18'h00000, 1, 1, 0, 1, 3});
    vecs.push_back('{0, 1, 0, 0, 18'h00000, 1, 1,  18'h00000, 0, 1, 0, 0, 0}); // load beats fetch
    vecs.push_back('{0, 0, 1, 0, 18'h00003, 0, 0,  18'h00000, 0, 0, 1, 0, 0}); // trit 0 illegal
    vecs.push_back('{0, 0, 1, 0, 18'h00155, 0, 0,  18'h00000, 0, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 18'h00030, 0, 0,  18'h00000, 0, 0, 1, 1, 1}); // bad word with last
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 0,  18'h00155, 1, 0, 1, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 1,  18'h00015, 1, 0, 1, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 2,  18'h2AAAA, 1, 0, 1, 1, 1});
    vecs.push_back('{0, 1, 0, 0, 18'h00000, 0, 0,  18'h2AAAA, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 18'h00001, 0, 0,  18'h2AAAA, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 18'h00002, 0, 0,  18'h2AAAA, 0, 0, 0, 0, 2});
    vecs.push_back('{1, 0, 1, 0, 18'h00004, 1, 0,  18'h00000, 0, 0, 0, 0, 0}); // reset mid-load
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 1, 0,  18'h00000, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 18'h00000, 0, 0,  18'h00000, 0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].ls, vecs[i].lv, vecs[i].ll, vecs[i].d, vecs[i].fe, vecs[i].p);
      check_outs($sformatf("vec%0d", i), vecs[i].ei, vecs[i].eiv, vecs[i].efe,
                 vecs[i].ele, vecs[i].eld, vecs[i].ec);
    end

    // Full-depth load with no load_last: the 28th word must be dropped
    apply(0, 1, 0, 0, '0, 0, 0);
    for (int k = 0; k < 28; k++) begin
      apply(0, 0, 1, 0, trit_word(k + 1), 0, 0);
      if (k >= 26) begin
        check($sformatf("depth_word%0d_count", k + 1), 32'(load_count), 32'd27);
        check($sformatf("depth_word%0d_loaded", k + 1), 32'(loaded), 32'd1);
      end
    end
    apply(0, 0, 0, 0, '0, 1, 5'd26);
    check("depth_mem26", 32'(instruction), 32'(trit_word(27)));
    check("depth_mem26_valid", 32'(instruction_valid), 32'd1);
    apply(0, 0, 0, 0, '0, 1, 5'd0);
    check("depth_mem0", 32'(instruction), 32'(trit_word(1)));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      d = 18'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < 9; i++) if (d[2*i +: 2] == 2'b11) d[2*i +: 2] = 2'b10;
      apply($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0, d,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
      check_outs($sformatf("rand%0d", n), m_instr, m_ival, m_ferr, m_lerr, m_ready,
                 6'(m_count));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
